// File: rtl/axis_burst_if.sv
// AXI4-Stream handshake bundle used by the burst scheduler and its consumers.
interface axis_burst_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_burst_scheduler.sv
// Fabric-side AXI4-Stream test source: arms on a GPIO key, pulses the AXI master start,
// then emits NUM_BURSTS counter-data bursts separated by fixed idle gaps.
module axis_burst_scheduler #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned GAP_CYCLES  = 22,
    parameter int unsigned NUM_BURSTS  = 100,
    parameter int unsigned DATA_WRAP   = 128,
    parameter int unsigned START_DELAY = 128,
    parameter logic [31:0] ENABLE_KEY  = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  en_gpio,
    axis_burst_if.master m_axis,
    output logic         init_axi_txn,
    output logic         busy,
    output logic         done,
    output logic [9:0]   burst_cnt,
    output logic [3:0]   led
);

    localparam int unsigned ArmW  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [ArmW-1:0]   ArmLast     = ArmW'(START_DELAY - 1);
    localparam logic [BeatW-1:0]  BeatLast    = BeatW'(BURST_LEN - 1);
    localparam logic [GapW-1:0]   GapLast     = GapW'(GAP_CYCLES - 1);
    localparam logic [DATA_W-1:0] DataLast    = DATA_W'(DATA_WRAP - 1);
    localparam logic [9:0]        BurstTarget = 10'(NUM_BURSTS);

    typedef enum logic [2:0] {StIdle, StArm, StBurst, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [ArmW-1:0]     arm_cnt_q, arm_cnt_d;
    logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [9:0]          burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic en;
    logic tvalid;
    logic tlast;
    logic xfer;
    logic [9:0] burst_inc;

    assign en        = (en_gpio == ENABLE_KEY);
    assign tvalid    = (state_q == StBurst);
    assign tlast     = tvalid && (beat_cnt_q == BeatLast);
    assign xfer      = tvalid && m_axis.tready;
    assign burst_inc = burst_cnt_q + 10'd1;

    always_comb begin
        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        burst_cnt_d = burst_cnt_q;
        data_d      = data_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d     = StArm;
                    arm_cnt_d   = '0;
                    beat_cnt_d  = '0;
                    burst_cnt_d = '0;
                    data_d      = '0;
                end
            end
            StArm: begin
                arm_cnt_d = arm_cnt_q + 1'b1;
                if (!en) begin
                    state_d = StIdle;
                end else if (arm_cnt_q == ArmLast) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (xfer) begin
                    data_d = (data_q == DataLast) ? '0 : data_q + 1'b1;
                    if (tlast) begin
                        beat_cnt_d  = '0;
                        burst_cnt_d = burst_inc;
                        // A dropped enable only takes effect once the burst is whole.
                        if (burst_inc == BurstTarget) begin
                            state_d = StDone;
                        end else if (!en) begin
                            state_d = StIdle;
                        end else if (GAP_CYCLES != 0) begin
                            state_d   = StGap;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (!en) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == GapLast) begin
                    state_d = StBurst;
                end
            end
            StDone: begin
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            arm_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            burst_cnt_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            data_q      <= data_d;
        end
    end

    assign m_axis.tvalid = tvalid;
    assign m_axis.tlast  = tlast;
    assign m_axis.tdata  = tvalid ? data_q : '0;

    // Counters keep stale values through IDLE until the next arm; hide them meanwhile.
    assign init_axi_txn = (state_q == StArm) && en && (arm_cnt_q == ArmLast);
    assign busy         = (state_q == StArm) || (state_q == StBurst) || (state_q == StGap);
    assign done         = (state_q == StDone);
    assign burst_cnt    = (state_q == StIdle) ? 10'd0 : burst_cnt_q;
    assign led          = done ? 4'b1111 : 4'b0000;

endmodule

// File: tb/tb_axis_burst_scheduler.sv
// Directed bench for axis_burst_scheduler: default instance plus a GAP=0/LEN=1/NUM=2 instance.
module tb_axis_burst_scheduler;

    localparam logic [31:0] Key = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] en_gpio;
    logic [31:0] en_gpio2;

    logic       init_a, busy_a, done_a;
    logic [9:0] bcnt_a;
    logic [3:0] led_a;
    logic       init_b, busy_b, done_b;
    logic [9:0] bcnt_b;
    logic [3:0] led_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_burst_if #(.DATA_W(32)) axis_a ();
    axis_burst_if #(.DATA_W(32)) axis_b ();

    axis_burst_scheduler dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_gpio      (en_gpio),
        .m_axis       (axis_a.master),
        .init_axi_txn (init_a),
        .busy         (busy_a),
        .done         (done_a),
        .burst_cnt    (bcnt_a),
        .led          (led_a)
    );

    axis_burst_scheduler #(
        .BURST_LEN   (1),
        .GAP_CYCLES  (0),
        .NUM_BURSTS  (2),
        .START_DELAY (4)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_gpio      (en_gpio2),
        .m_axis       (axis_b.master),
        .init_axi_txn (init_b),
        .busy         (busy_b),
        .done         (done_b),
        .burst_cnt    (bcnt_b),
        .led          (led_b)
    );

    // One clock cycle: drive inputs at the falling edge, return 1 ns later for sampling.
    task automatic cyc(input logic [31:0] g, input logic r);
        @(negedge clk);
        en_gpio       = g;
        axis_a.tready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        en_gpio       = '0;
        en_gpio2      = '0;
        axis_a.tready = 1'b0;
        axis_b.tready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int busy_seen;
        @(negedge clk);
        rst_n    = 1'b0;
        en_gpio  = Key;
        en_gpio2 = Key;
        #1;
        total++;
        if ({axis_a.tvalid, axis_a.tlast, init_a, busy_a, done_a} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {axis_a.tvalid, axis_a.tlast, init_a, busy_a, done_a});
        end
        total++;
        if (axis_a.tdata !== 32'd0 || bcnt_a !== 10'd0 || led_a !== 4'd0) begin
            bad++;
            $display("FAIL reset_values: got tdata=%0h bcnt=%0d led=%0h want 0 0 0",
                     axis_a.tdata, bcnt_a, led_a);
        end
        do_reset();
        busy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(32'h7FFF_FFFF, 1'b1);
            if (busy_a) busy_seen++;
        end
        total++;
        if (busy_seen !== 0) begin
            bad++;
            $display("FAIL near_key_ignored: got busy_cycles=%0d want 0", busy_seen);
        end
    endtask

    task automatic test_nominal();
        int xf, seq_err, init_cyc, beat16_cyc, done_cyc, n;
        logic [31:0] beat16_data;
        logic exp_valid;
        xf = 0; seq_err = 0; init_cyc = -1; beat16_cyc = -1; done_cyc = -1;
        beat16_data = '1;
        do_reset();
        for (int c = 0; c <= 3910; c++) begin
            cyc(Key, 1'b1);
            exp_valid = (c >= 129) && (c <= 3906) && (((c - 129) % 38) < 16);
            if (axis_a.tvalid !== exp_valid) seq_err++;
            if (init_a !== (c == 128)) seq_err++;
            if (busy_a !== (c >= 1 && c <= 3906)) seq_err++;
            if (done_a !== (c >= 3907)) seq_err++;
            if (led_a !== ((c >= 3907) ? 4'hF : 4'h0)) seq_err++;
            if (bcnt_a !== 10'(xf / 16)) seq_err++;
            if (exp_valid) begin
                n = ((c - 129) / 38) * 16 + ((c - 129) % 38);
                if (axis_a.tdata !== 32'(n % 128)) seq_err++;
                if (axis_a.tlast !== ((n % 16) == 15)) seq_err++;
            end
            if (init_a === 1'b1 && init_cyc < 0) init_cyc = c;
            if (done_a === 1'b1 && done_cyc < 0) done_cyc = c;
            if (axis_a.tvalid === 1'b1) begin
                if (xf == 16) begin
                    beat16_cyc  = c;
                    beat16_data = axis_a.tdata;
                end
                xf++;
            end
        end
        total++;
        if (seq_err !== 0) begin
            bad++;
            $display("FAIL nominal_cycle_model: got %0d mismatching samples want 0", seq_err);
        end
        total++;
        if (init_cyc !== 128) begin
            bad++;
            $display("FAIL nominal_init_cycle: got %0d want 128", init_cyc);
        end
        total++;
        if (beat16_cyc !== 167 || beat16_data !== 32'd16) begin
            bad++;
            $display("FAIL nominal_second_burst: got cycle=%0d data=%0d want 167 16",
                     beat16_cyc, beat16_data);
        end
        total++;
        if (xf !== 1600) begin
            bad++;
            $display("FAIL nominal_xfers: got %0d want 1600", xf);
        end
        total++;
        if (done_cyc !== 3907) begin
            bad++;
            $display("FAIL nominal_done_cycle: got %0d want 3907", done_cyc);
        end
        total++;
        if (bcnt_a !== 10'd100 || led_a !== 4'hF) begin
            bad++;
            $display("FAIL nominal_final: got bcnt=%0d led=%0h want 100 f", bcnt_a, led_a);
        end
    endtask

    task automatic test_random_tready();
        int xf, errs, c, last_tlast_cyc, done_cyc;
        logic prev_stall, prev_valid, prev_last;
        logic [31:0] prev_data;
        xf = 0; errs = 0; c = 0; last_tlast_cyc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_valid = 1'b0; prev_last = 1'b0; prev_data = '0;
        do_reset();
        while (c < 12000 && done_cyc < 0) begin
            cyc(Key, 1'($urandom_range(0, 1)));
            if (prev_stall && (axis_a.tvalid !== 1'b1 || axis_a.tdata !== prev_data ||
                               axis_a.tlast !== prev_last)) errs++;
            if (axis_a.tvalid && !prev_valid && last_tlast_cyc >= 0 &&
                (c - last_tlast_cyc) != 23) errs++;
            if (axis_a.tvalid && axis_a.tready) begin
                if (axis_a.tdata !== 32'(xf % 128)) errs++;
                if (axis_a.tlast !== ((xf % 16) == 15)) errs++;
                if (axis_a.tlast) last_tlast_cyc = c;
                xf++;
            end
            prev_stall = axis_a.tvalid && !axis_a.tready;
            prev_valid = axis_a.tvalid;
            prev_data  = axis_a.tdata;
            prev_last  = axis_a.tlast;
            if (done_a === 1'b1) done_cyc = c;
            c++;
        end
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL random_timeout: got no done within %0d cycles want done", c);
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL random_scoreboard: got %0d errors want 0", errs);
        end
        total++;
        if (xf !== 1600 || bcnt_a !== 10'd100) begin
            bad++;
            $display("FAIL random_counts: got xfers=%0d bcnt=%0d want 1600 100", xf, bcnt_a);
        end
        total++;
        if (done_cyc >= 0 && (done_cyc - last_tlast_cyc) !== 1) begin
            bad++;
            $display("FAIL random_done_latency: got %0d want 1", done_cyc - last_tlast_cyc);
        end
    endtask

    task automatic test_en_drop_burst();
        int xf_after, late_valid, busy145, bcnt150, init_cyc;
        logic [31:0] data134, first_data;
        logic [9:0]  bcnt_arm;
        xf_after = 0; late_valid = 0; busy145 = -1; bcnt150 = -1; init_cyc = -1;
        data134 = '1; first_data = '1; bcnt_arm = '1;
        do_reset();
        for (int c = 0; c <= 200; c++) begin
            cyc((c < 134) ? Key : 32'd0, 1'b1);
            if (c == 134) data134 = axis_a.tdata;
            if (c >= 134 && c < 145 && axis_a.tvalid) xf_after++;
            if (c >= 145 && axis_a.tvalid) late_valid++;
            if (c == 145) busy145 = int'(busy_a);
            if (c == 150) bcnt150 = int'(bcnt_a);
        end
        total++;
        if (data134 !== 32'd5 || xf_after !== 11) begin
            bad++;
            $display("FAIL drop_burst_tail: got data=%0d beats=%0d want 5 11", data134, xf_after);
        end
        total++;
        if (busy145 !== 0 || late_valid !== 0) begin
            bad++;
            $display("FAIL drop_burst_idle: got busy=%0d late_valid=%0d want 0 0",
                     busy145, late_valid);
        end
        total++;
        if (bcnt150 !== 0) begin
            bad++;
            $display("FAIL drop_burst_bcnt_idle: got %0d want 0", bcnt150);
        end
        for (int c = 0; c <= 129; c++) begin
            cyc(Key, 1'b1);
            if (c == 64) bcnt_arm = bcnt_a;
            if (init_a === 1'b1 && init_cyc < 0) init_cyc = c;
            if (c == 129) first_data = axis_a.tvalid ? axis_a.tdata : 32'hDEAD;
        end
        total++;
        if (init_cyc !== 128 || first_data !== 32'd0 || bcnt_arm !== 10'd0) begin
            bad++;
            $display("FAIL drop_burst_restart: got init=%0d data=%0h bcnt=%0d want 128 0 0",
                     init_cyc, first_data, bcnt_arm);
        end
    endtask

    task automatic test_en_drop_arm_gap();
        int inits, valids, busy50, busy51, busy150, busy151, valid150, bcnt150;
        inits = 0; valids = 0; busy50 = -1; busy51 = -1;
        do_reset();
        for (int c = 0; c <= 300; c++) begin
            cyc((c < 50) ? Key : 32'hFFFF_FFFE, 1'b1);
            if (init_a) inits++;
            if (axis_a.tvalid) valids++;
            if (c == 50) busy50 = int'(busy_a);
            if (c == 51) busy51 = int'(busy_a);
        end
        total++;
        if (inits !== 0 || valids !== 0) begin
            bad++;
            $display("FAIL drop_arm_quiet: got inits=%0d valids=%0d want 0 0", inits, valids);
        end
        total++;
        if (busy50 !== 1 || busy51 !== 0) begin
            bad++;
            $display("FAIL drop_arm_busy: got %0d->%0d want 1->0", busy50, busy51);
        end
        inits = 0; valids = 0; busy150 = -1; busy151 = -1; valid150 = -1; bcnt150 = -1;
        for (int c = 0; c <= 260; c++) begin
            cyc((c < 150) ? Key : 32'd0, 1'b1);
            if (init_a) inits++;
            if (c >= 151 && axis_a.tvalid) valids++;
            if (c == 150) begin
                busy150  = int'(busy_a);
                valid150 = int'(axis_a.tvalid);
                bcnt150  = int'(bcnt_a);
            end
            if (c == 151) busy151 = int'(busy_a);
        end
        total++;
        if (busy150 !== 1 || valid150 !== 0 || bcnt150 !== 1) begin
            bad++;
            $display("FAIL drop_gap_state: got busy=%0d valid=%0d bcnt=%0d want 1 0 1",
                     busy150, valid150, bcnt150);
        end
        total++;
        if (busy151 !== 0 || valids !== 0 || inits !== 1) begin
            bad++;
            $display("FAIL drop_gap_idle: got busy=%0d valids=%0d inits=%0d want 0 0 1",
                     busy151, valids, inits);
        end
    endtask

    task automatic test_reset_mid_burst();
        int inits, init_cyc;
        logic [31:0] stall_data;
        logic        stall_valid;
        inits = 0; init_cyc = -1;
        do_reset();
        for (int c = 0; c <= 137; c++) begin
            cyc(Key, (c < 135) ? 1'b1 : 1'b0);
        end
        stall_valid = axis_a.tvalid;
        stall_data  = axis_a.tdata;
        total++;
        if (stall_valid !== 1'b1 || stall_data !== 32'd6) begin
            bad++;
            $display("FAIL rst_pre_stall: got valid=%b data=%0d want 1 6", stall_valid, stall_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({axis_a.tvalid, axis_a.tlast, init_a, busy_a, done_a} !== 5'b0 ||
            axis_a.tdata !== 32'd0 || bcnt_a !== 10'd0 || led_a !== 4'd0) begin
            bad++;
            $display("FAIL rst_async_outputs: got flags=%b tdata=%0h bcnt=%0d led=%0h want 0",
                     {axis_a.tvalid, axis_a.tlast, init_a, busy_a, done_a},
                     axis_a.tdata, bcnt_a, led_a);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        en_gpio       = Key;
        axis_a.tready = 1'b1;
        #1;
        for (int c = 1; c <= 140; c++) begin
            cyc(Key, 1'b1);
            if (init_a) begin
                inits++;
                if (init_cyc < 0) init_cyc = c;
            end
        end
        total++;
        if (inits !== 1 || init_cyc !== 128) begin
            bad++;
            $display("FAIL rst_rearm: got inits=%0d cycle=%0d want 1 128", inits, init_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int init_cyc, done_cyc, xf, tlast_err;
        int xf_cyc[2];
        logic [31:0] xf_data[2];
        logic [9:0]  bcnt6;
        init_cyc = -1; done_cyc = -1; xf = 0; tlast_err = 0; bcnt6 = '1;
        xf_cyc[0] = -1; xf_cyc[1] = -1; xf_data[0] = '1; xf_data[1] = '1;
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            en_gpio2      = Key;
            en_gpio       = '0;
            axis_b.tready = 1'b1;
            #1;
            if (init_b === 1'b1 && init_cyc < 0) init_cyc = c;
            if (done_b === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == 6) bcnt6 = bcnt_b;
            if (axis_b.tvalid === 1'b1) begin
                if (axis_b.tlast !== 1'b1) tlast_err++;
                if (xf < 2) begin
                    xf_cyc[xf]  = c;
                    xf_data[xf] = axis_b.tdata;
                end
                xf++;
            end
        end
        total++;
        if (init_cyc !== 4) begin
            bad++;
            $display("FAIL b2b_init_cycle: got %0d want 4", init_cyc);
        end
        total++;
        if (xf !== 2 || xf_cyc[0] !== 5 || xf_cyc[1] !== 6 || tlast_err !== 0) begin
            bad++;
            $display("FAIL b2b_beats: got n=%0d cycles=%0d,%0d tlast_err=%0d want 2 5,6 0",
                     xf, xf_cyc[0], xf_cyc[1], tlast_err);
        end
        total++;
        if (xf_data[0] !== 32'd0 || xf_data[1] !== 32'd1) begin
            bad++;
            $display("FAIL b2b_data: got %0d,%0d want 0,1", xf_data[0], xf_data[1]);
        end
        total++;
        if (done_cyc !== 7 || bcnt6 !== 10'd1 || bcnt_b !== 10'd2 || led_b !== 4'hF) begin
            bad++;
            $display("FAIL b2b_done: got done=%0d bcnt6=%0d bcnt=%0d led=%0h want 7 1 2 f",
                     done_cyc, bcnt6, bcnt_b, led_b);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        en_gpio       = '0;
        en_gpio2      = '0;
        axis_a.tready = 1'b0;
        axis_b.tready = 1'b1;
        test_reset();
        test_nominal();
        test_random_tready();
        test_en_drop_burst();
        test_en_drop_arm_gap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
